// File: rtl/som_pkg.sv
// Shared definitions for the note playback path: state codes (also used to
// decode db_estado on the display), silence code and default widths.
package som_pkg;

  localparam int unsigned NOTE_W_PADRAO = 4;
  localparam int unsigned ADDR_W_PADRAO = 4;
  localparam int unsigned NOTA_SILENCIO = 0;

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    LE_MEM = 3'd1,
    TOCA   = 3'd2,
    PAUSA  = 3'd3,
    PROX   = 3'd4,
    FIM    = 3'd5
  } estado_t;

endpackage

// File: rtl/contador_ticks.sv
// Tick-enabled counter with synchronous clear; terminal flags a tick that
// lands on the programmed limit.
module contador_ticks #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             limpa,
  input  logic             tick,
  input  logic [WIDTH-1:0] limite,
  output logic [WIDTH-1:0] valor,
  output logic             terminal
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      valor <= '0;
    else if (limpa) valor <= '0;
    else if (tick)  valor <= valor + WIDTH'(1);
  end

  assign terminal = tick && (valor == limite);

endmodule

// File: rtl/sequenciador_notas.sv
// Note playback sequencer: plays notes 0..limite from music memory, each for
// DUR_NOTA ticks followed by DUR_PAUSA ticks of silence. Optional idle button
// echo is enabled with `define SEQ_ECO_BOTAO_EN.
module sequenciador_notas
  import som_pkg::*;
#(
  parameter int unsigned NOTE_W    = NOTE_W_PADRAO,
  parameter int unsigned ADDR_W    = ADDR_W_PADRAO,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned DUR_NOTA  = 500,
  parameter int unsigned DUR_PAUSA = 100
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              abortar,
  input  logic [ADDR_W-1:0] limite,
  input  logic              tick,
  output logic [ADDR_W-1:0] mem_endereco,
  input  logic [NOTE_W-1:0] mem_dado,
  input  logic [NOTE_W-1:0] botoes,
  output logic [NOTE_W-1:0] nota_saida,
  output logic              nota_valida,
  output logic              muda_nota,
  output logic              ocupado,
  output logic              fim,
  output logic [2:0]        db_estado
);

  estado_t           estado, proximo;
  logic [ADDR_W-1:0] endereco, limite_reg;
  logic [CNT_W-1:0]  limite_cnt;
  logic              cnt_limpa, cnt_fim, aceita;
  logic              tem_nota;

  contador_ticks #(.WIDTH(CNT_W)) u_contador (
    .clock    (clock),
    .reset    (reset),
    .limpa    (cnt_limpa),
    .tick     (tick),
    .limite   (limite_cnt),
    .valor    (),
    .terminal (cnt_fim)
  );

  assign limite_cnt = (estado == TOCA) ? CNT_W'(DUR_NOTA - 1) : CNT_W'(DUR_PAUSA - 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= proximo;
  end

  always_comb begin
    proximo   = estado;
    muda_nota = 1'b0;
    fim       = 1'b0;
    cnt_limpa = 1'b1;
    aceita    = 1'b0;
    case (estado)
      OCIOSO: if (iniciar) begin
        proximo = LE_MEM;
        aceita  = 1'b1;
      end
      LE_MEM: proximo = TOCA;
      TOCA: begin
        cnt_limpa = cnt_fim;
        if (cnt_fim) begin
          muda_nota = 1'b1;
          proximo   = PAUSA;
        end
      end
      PAUSA: begin
        cnt_limpa = cnt_fim;
        if (cnt_fim) proximo = (endereco == limite_reg) ? FIM : PROX;
      end
      PROX: proximo = LE_MEM;
      FIM: begin
        fim     = 1'b1;
        proximo = OCIOSO;
      end
      default: proximo = OCIOSO;
    endcase
    if (abortar) begin
      proximo   = OCIOSO;
      muda_nota = 1'b0;
      fim       = 1'b0;
      aceita    = 1'b0;
      cnt_limpa = 1'b1;
    end
  end

  // The address is advanced when leaving PAUSA and held at 0 while idle, so
  // the synchronous memory already presents the next note when LE_MEM ends.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      endereco   <= '0;
      limite_reg <= '0;
      nota_saida <= '0;
    end else begin
      if (proximo == OCIOSO)                        endereco <= '0;
      else if (estado == PAUSA && proximo == PROX)  endereco <= endereco + ADDR_W'(1);
      if (aceita) limite_reg <= limite;
      if (proximo == TOCA) begin
        if (estado == LE_MEM) nota_saida <= mem_dado;
      end else if (estado == OCIOSO && proximo == OCIOSO) begin
`ifdef SEQ_ECO_BOTAO_EN
        nota_saida <= botoes;
`else
        nota_saida <= '0;
`endif
      end else begin
        nota_saida <= '0;
      end
    end
  end

  assign tem_nota = (nota_saida != NOTE_W'(NOTA_SILENCIO));

`ifdef SEQ_ECO_BOTAO_EN
  assign nota_valida = tem_nota && (estado == TOCA || estado == OCIOSO);
`else
  logic unused_botoes;
  assign unused_botoes = ^botoes;
  assign nota_valida   = tem_nota && (estado == TOCA);
`endif

  assign mem_endereco = endereco;
  assign ocupado      = (estado != OCIOSO);
  assign db_estado    = estado;

endmodule

// File: tb/tb_sequenciador_notas.sv
// Directed bench for sequenciador_notas with DUR_NOTA=3, DUR_PAUSA=2.
module tb_sequenciador_notas;

  logic       clock = 1'b0;
  logic       reset, iniciar, abortar, tick;
  logic [3:0] limite, botoes, mem_dado, nota_saida, mem_endereco;
  logic       nota_valida, muda_nota, ocupado, fim;
  logic [2:0] db_estado;
  logic [3:0] mem [16];
  int checks = 0;
  int errors = 0;

  sequenciador_notas #(.DUR_NOTA(3), .DUR_PAUSA(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .abortar      (abortar),
    .limite       (limite),
    .tick         (tick),
    .mem_endereco (mem_endereco),
    .mem_dado     (mem_dado),
    .botoes       (botoes),
    .nota_saida   (nota_saida),
    .nota_valida  (nota_valida),
    .muda_nota    (muda_nota),
    .ocupado      (ocupado),
    .fim          (fim),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) mem_dado <= mem[mem_endereco];

  task automatic test_reset();
    reset = 1'b1; iniciar = 1'b0; abortar = 1'b0; tick = 1'b0;
    limite = '0; botoes = '0;
    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({nota_saida, nota_valida} !== 5'd0) begin
      errors++; $display("FAIL reset_nota: got %0h expected 0", {nota_saida, nota_valida});
    end
    checks++;
    if ({muda_nota, ocupado, fim} !== 3'd0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {muda_nota, ocupado, fim});
    end
    checks++;
    if ({db_estado, mem_endereco} !== 7'd0) begin
      errors++; $display("FAIL reset_estado: got %0h expected 0", {db_estado, mem_endereco});
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_three_notes(input bit repulse);
    int   exp_st [24] = '{0,1,2,2,2,3,3,4,1,2,2,2,3,3,4,1,2,2,2,3,3,5,0,0};
    logic e;
    mem[0] = 4'd5; mem[1] = 4'd0; mem[2] = 4'd9; mem[3] = 4'd4;
    limite = 4'd2; tick = 1'b1;
    for (int c = 0; c < 24; c++) begin
      iniciar = (c == 0) || (repulse && c == 3);
      if (repulse && c == 3) limite = 4'd5;
      @(negedge clock);
      checks++;
      if (db_estado !== 3'(exp_st[c])) begin
        errors++; $display("FAIL seq%0d_estado: cycle %0d got %0d expected %0d", repulse, c, db_estado, exp_st[c]);
      end
      e = (c >= 2 && c <= 4) || (c >= 16 && c <= 18);
      checks++;
      if (nota_valida !== e) begin
        errors++; $display("FAIL seq%0d_valida: cycle %0d got %b expected %b", repulse, c, nota_valida, e);
      end
      e = (c == 4) || (c == 11) || (c == 18);
      checks++;
      if (muda_nota !== e) begin
        errors++; $display("FAIL seq%0d_muda: cycle %0d got %b expected %b", repulse, c, muda_nota, e);
      end
      e = (c == 21);
      checks++;
      if (fim !== e) begin
        errors++; $display("FAIL seq%0d_fim: cycle %0d got %b expected %b", repulse, c, fim, e);
      end
      e = (c >= 1 && c <= 21);
      checks++;
      if (ocupado !== e) begin
        errors++; $display("FAIL seq%0d_ocupado: cycle %0d got %b expected %b", repulse, c, ocupado, e);
      end
      if (c >= 2 && c <= 4) begin
        checks++;
        if (nota_saida !== 4'd5) begin
          errors++; $display("FAIL seq%0d_nota: cycle %0d got %0d expected 5", repulse, c, nota_saida);
        end
      end else if (c >= 9 && c <= 11) begin
        checks++;
        if (nota_saida !== 4'd0) begin
          errors++; $display("FAIL seq%0d_nota: cycle %0d got %0d expected 0", repulse, c, nota_saida);
        end
      end else if (c >= 16 && c <= 18) begin
        checks++;
        if (nota_saida !== 4'd9) begin
          errors++; $display("FAIL seq%0d_nota: cycle %0d got %0d expected 9", repulse, c, nota_saida);
        end
      end
      @(posedge clock); #1;
    end
    iniciar = 1'b0;
  endtask

  task automatic test_single_note();
    logic e;
    mem[0] = 4'd7; mem[1] = 4'd9;
    limite = 4'd0; tick = 1'b1;
    for (int c = 0; c < 10; c++) begin
      iniciar = (c == 0);
      @(negedge clock);
      e = (c >= 2 && c <= 4);
      checks++;
      if (nota_valida !== e) begin
        errors++; $display("FAIL single_valida: cycle %0d got %b expected %b", c, nota_valida, e);
      end
      if (e) begin
        checks++;
        if (nota_saida !== 4'd7) begin
          errors++; $display("FAIL single_nota: cycle %0d got %0d expected 7", c, nota_saida);
        end
      end
      e = (c == 4);
      checks++;
      if (muda_nota !== e) begin
        errors++; $display("FAIL single_muda: cycle %0d got %b expected %b", c, muda_nota, e);
      end
      e = (c == 7);
      checks++;
      if (fim !== e) begin
        errors++; $display("FAIL single_fim: cycle %0d got %b expected %b", c, fim, e);
      end
      e = (c >= 1 && c <= 7);
      checks++;
      if (ocupado !== e) begin
        errors++; $display("FAIL single_ocupado: cycle %0d got %b expected %b", c, ocupado, e);
      end
      checks++;
      if (mem_endereco !== 4'd0) begin
        errors++; $display("FAIL single_endereco: cycle %0d got %0d expected 0", c, mem_endereco);
      end
      @(posedge clock); #1;
    end
    iniciar = 1'b0;
  endtask

  task automatic test_abort();
    logic e;
    mem[0] = 4'd5; mem[1] = 4'd0; mem[2] = 4'd9;
    limite = 4'd2; tick = 1'b1;
    for (int c = 0; c < 27; c++) begin
      iniciar = (c == 0) || (c == 16);
      abortar = (c == 10) || (c == 24);
      @(negedge clock);
      e = (c >= 2 && c <= 4) || (c >= 18 && c <= 20);
      checks++;
      if (nota_valida !== e) begin
        errors++; $display("FAIL abort_valida: cycle %0d got %b expected %b", c, nota_valida, e);
      end
      e = (c == 4) || (c == 20);
      checks++;
      if (muda_nota !== e) begin
        errors++; $display("FAIL abort_muda: cycle %0d got %b expected %b", c, muda_nota, e);
      end
      checks++;
      if (fim !== 1'b0) begin
        errors++; $display("FAIL abort_fim: cycle %0d got %b expected 0", c, fim);
      end
      e = (c >= 1 && c <= 10) || (c >= 17 && c <= 24);
      checks++;
      if (ocupado !== e) begin
        errors++; $display("FAIL abort_ocupado: cycle %0d got %b expected %b", c, ocupado, e);
      end
      if (c == 11 || c == 17) begin
        checks++;
        if (mem_endereco !== 4'd0) begin
          errors++; $display("FAIL abort_endereco: cycle %0d got %0d expected 0", c, mem_endereco);
        end
      end
      if (c == 18) begin
        checks++;
        if (nota_saida !== 4'd5) begin
          errors++; $display("FAIL abort_restart_nota: cycle %0d got %0d expected 5", c, nota_saida);
        end
      end
      @(posedge clock); #1;
    end
    iniciar = 1'b0; abortar = 1'b0;
  endtask

  task automatic test_sparse_tick();
    logic e;
    mem[0] = 4'd5;
    limite = 4'd0;
    for (int c = 0; c < 7; c++) begin
      iniciar = (c == 0);
      tick = (c % 4 == 3);
      @(negedge clock);
      if (c >= 2) begin
        checks++;
        if ({db_estado, nota_saida, nota_valida, muda_nota} !== {3'd2, 4'd5, 1'b1, 1'b0}) begin
          errors++; $display("FAIL sparse_hold: cycle %0d got %0h expected %0h", c,
                             {db_estado, nota_saida, nota_valida, muda_nota}, {3'd2, 4'd5, 1'b1, 1'b0});
        end
      end
      if (c == 6) begin
        reset = 1'b1;
        #1;
        checks++;
        if ({nota_saida, nota_valida, muda_nota, ocupado, fim, db_estado, mem_endereco} !== 16'd0) begin
          errors++; $display("FAIL async_reset: got %0h expected 0",
                             {nota_saida, nota_valida, muda_nota, ocupado, fim, db_estado, mem_endereco});
        end
      end
      @(posedge clock); #1;
    end
    iniciar = 1'b0; tick = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    for (int c = 0; c < 23; c++) begin
      iniciar = (c == 0);
      tick = (c % 4 == 3);
      @(negedge clock);
      e = (c >= 2 && c <= 11);
      checks++;
      if (nota_valida !== e) begin
        errors++; $display("FAIL sparse_valida: cycle %0d got %b expected %b", c, nota_valida, e);
      end
      e = (c == 11);
      checks++;
      if (muda_nota !== e) begin
        errors++; $display("FAIL sparse_muda: cycle %0d got %b expected %b", c, muda_nota, e);
      end
      e = (c == 20);
      checks++;
      if (fim !== e) begin
        errors++; $display("FAIL sparse_fim: cycle %0d got %b expected %b", c, fim, e);
      end
      e = (c >= 1 && c <= 20);
      checks++;
      if (ocupado !== e) begin
        errors++; $display("FAIL sparse_ocupado: cycle %0d got %b expected %b", c, ocupado, e);
      end
      if (c == 12 || c == 19) begin
        checks++;
        if (db_estado !== 3'd3) begin
          errors++; $display("FAIL sparse_pausa: cycle %0d got %0d expected 3", c, db_estado);
        end
      end
      @(posedge clock); #1;
    end
    iniciar = 1'b0; tick = 1'b0;
  endtask

  task automatic test_echo();
    logic [4:0] exp_v [8];
`ifdef SEQ_ECO_BOTAO_EN
    exp_v = '{5'h00, 5'h07, 5'h07, 5'h00, 5'h0B, 5'h0B, 5'h00, 5'h07};
`else
    exp_v = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h0B, 5'h0B, 5'h00, 5'h00};
`endif
    mem[0] = 4'd5;
    limite = 4'd0; tick = 1'b1; botoes = 4'd3;
    for (int c = 0; c < 8; c++) begin
      iniciar = (c == 2);
      abortar = (c == 5);
      @(negedge clock);
      checks++;
      if ({nota_saida, nota_valida} !== exp_v[c]) begin
        errors++; $display("FAIL echo: cycle %0d got nota %0d valida %b expected nota %0d valida %b",
                           c, nota_saida, nota_valida, exp_v[c][4:1], exp_v[c][0]);
      end
      @(posedge clock); #1;
    end
    iniciar = 1'b0; abortar = 1'b0; botoes = 4'd0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    test_reset();
    test_three_notes(1'b0);
    test_single_note();
    test_abort();
    test_three_notes(1'b1);
    test_sparse_tick();
    test_echo();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
